// File: rtl/msxbus_pkg.sv
// Shared MSX bus definitions: phase encodings and default bus timing,
// used by both the bus master and the receiving bus-interface block.
package msxbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } msx_state_e;

  localparam int unsigned MSX_T_SETUP  = 2;
  localparam int unsigned MSX_T_STROBE = 4;
  localparam int unsigned MSX_T_HOLD   = 2;
  localparam int unsigned MSX_WAIT_MAX = 255;

  localparam int unsigned MSX_PHASE_W = 4;
  localparam int unsigned MSX_WAIT_W  = 8;

endpackage

// File: rtl/ip_msxbus_sync.sv
// Two-flop synchroniser for the asynchronous active-low MSX wait request.
module ip_msxbus_sync (
  input  logic clk,
  input  logic n_reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/ip_msxbus_master.sv
// MSX bus master: turns a valid/ready request into a timed SETUP/STROBE/HOLD
// bus cycle with n_wait stretching, and reports completion with a one-cycle pulse.
module ip_msxbus_master
  import msxbus_pkg::*;
#(
  parameter int unsigned T_SETUP  = MSX_T_SETUP,
  parameter int unsigned T_STROBE = MSX_T_STROBE,
  parameter int unsigned T_HOLD   = MSX_T_HOLD,
  parameter int unsigned WAIT_MAX = MSX_WAIT_MAX
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [15:0] req_address,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [15:0] adr,
  output logic [7:0]  o_data,
  output logic        is_output,
  input  logic [7:0]  i_data,
  output logic        n_sltsl,
  output logic        n_mereq,
  output logic        n_ioreq,
  output logic        n_rd,
  output logic        n_wr,
  input  logic        n_wait
);

  msx_state_e state_q, state_d;
  logic [MSX_PHASE_W-1:0] cnt_q, cnt_d;
  logic [MSX_WAIT_W-1:0]  w_q, w_d;
  logic        wr_q, wr_d, io_q, io_d, tmo_q, tmo_d;
  logic [15:0] adr_q, adr_d;
  logic [7:0]  odata_q, odata_d, rdata_q;
  logic        ready_q, rspv_q, rsptmo_q, isout_q;
  logic        n_sltsl_q, n_mereq_q, n_ioreq_q, n_rd_q, n_wr_q;
  logic        wait_n_s, leave_strobe, done, active_d, strobe_d;

  ip_msxbus_sync u_wait_sync (
    .clk    (clk),
    .n_reset(n_reset),
    .async_i(n_wait),
    .sync_o (wait_n_s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_d          = w_q;
    tmo_d        = tmo_q;
    wr_d         = wr_q;
    io_d         = io_q;
    adr_d        = adr_q;
    odata_d      = odata_q;
    leave_strobe = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          w_d     = '0;
          tmo_d   = 1'b0;
          wr_d    = req_write;
          io_d    = req_io;
          adr_d   = req_address;
          odata_d = req_wdata;
        end
      end
      ST_SETUP: begin
        if (cnt_q == MSX_PHASE_W'(T_SETUP - 1)) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STROBE: begin
        // The phase counter parks on its last value while wait cycles are added.
        if (cnt_q == MSX_PHASE_W'(T_STROBE - 1)) begin
          if (!wait_n_s && (w_q != MSX_WAIT_W'(WAIT_MAX))) begin
            w_d = w_q + 1'b1;
          end else begin
            state_d      = ST_HOLD;
            cnt_d        = '0;
            tmo_d        = !wait_n_s;
            leave_strobe = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == MSX_PHASE_W'(T_HOLD - 1)) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they change only at edges.
  assign active_d = (state_d == ST_SETUP) || (state_d == ST_STROBE);
  assign strobe_d = (state_d == ST_STROBE);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      w_q       <= '0;
      wr_q      <= 1'b0;
      io_q      <= 1'b0;
      tmo_q     <= 1'b0;
      adr_q     <= '0;
      odata_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      rspv_q    <= 1'b0;
      rsptmo_q  <= 1'b0;
      isout_q   <= 1'b0;
      n_sltsl_q <= 1'b1;
      n_mereq_q <= 1'b1;
      n_ioreq_q <= 1'b1;
      n_rd_q    <= 1'b1;
      n_wr_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      wr_q      <= wr_d;
      io_q      <= io_d;
      tmo_q     <= tmo_d;
      adr_q     <= adr_d;
      odata_q   <= odata_d;
      if (leave_strobe && !wr_q) rdata_q <= i_data;
      ready_q   <= (state_d == ST_IDLE);
      rspv_q    <= done;
      rsptmo_q  <= done && tmo_q;
      isout_q   <= (state_d != ST_IDLE) && wr_d;
      n_sltsl_q <= !(active_d && !io_d);
      n_mereq_q <= !(active_d && !io_d);
      n_ioreq_q <= !(active_d && io_d);
      n_rd_q    <= !(strobe_d && !wr_d);
      n_wr_q    <= !(strobe_d && wr_d);
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rspv_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_timeout = rsptmo_q;
  assign adr         = adr_q;
  assign o_data      = odata_q;
  assign is_output   = isout_q;
  assign n_sltsl     = n_sltsl_q;
  assign n_mereq     = n_mereq_q;
  assign n_ioreq     = n_ioreq_q;
  assign n_rd        = n_rd_q;
  assign n_wr        = n_wr_q;

endmodule

// File: tb/tb_ip_msxbus_master.sv
// Bench for ip_msxbus_master: two instances (default and WAIT_MAX=4) checked each
// cycle against a timeline model, plus directed scenarios with literal expectations.
module tb_ip_msxbus_master;

  localparam int TS = 2, TSTR = 4, TH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset, req_valid, req_write, req_io, n_wait;
  logic [15:0] req_address;
  logic [7:0]  req_wdata, i_data;

  logic        o_ready[2], o_rspv[2], o_tmo[2], o_isout[2];
  logic        o_sltsl[2], o_mereq[2], o_ioreq[2], o_rd[2], o_wr[2];
  logic [7:0]  o_rdata[2], o_odata[2];
  logic [15:0] o_adr[2];

  ip_msxbus_master dut (
    .clk(clk), .n_reset(n_reset), .req_valid(req_valid), .req_ready(o_ready[0]),
    .req_write(req_write), .req_io(req_io), .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(o_rspv[0]), .rsp_rdata(o_rdata[0]), .rsp_timeout(o_tmo[0]),
    .adr(o_adr[0]), .o_data(o_odata[0]), .is_output(o_isout[0]), .i_data(i_data),
    .n_sltsl(o_sltsl[0]), .n_mereq(o_mereq[0]), .n_ioreq(o_ioreq[0]),
    .n_rd(o_rd[0]), .n_wr(o_wr[0]), .n_wait(n_wait)
  );

  ip_msxbus_master #(.WAIT_MAX(4)) dut_w4 (
    .clk(clk), .n_reset(n_reset), .req_valid(req_valid), .req_ready(o_ready[1]),
    .req_write(req_write), .req_io(req_io), .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(o_rspv[1]), .rsp_rdata(o_rdata[1]), .rsp_timeout(o_tmo[1]),
    .adr(o_adr[1]), .o_data(o_odata[1]), .is_output(o_isout[1]), .i_data(i_data),
    .n_sltsl(o_sltsl[1]), .n_mereq(o_mereq[1]), .n_ioreq(o_ioreq[1]),
    .n_rd(o_rd[1]), .n_wr(o_wr[1]), .n_wait(n_wait)
  );

  int total = 0;
  int bad   = 0;

  // Model: each transaction is a timeline relative to its accept cycle a.
  int          cyc     = 0;
  bit          started = 0;
  bit          rst_now = 0;
  bit          hist[8] = '{default: 1'b1};
  int          wmax[2] = '{255, 4};
  bit          busy[2] = '{0, 0};
  int          a[2]    = '{0, 0};
  int          e[2]    = '{-1, -1};
  int          rsp_c[2] = '{-1, -1};
  bit          m_wr[2]  = '{0, 0};
  bit          m_io[2]  = '{0, 0};
  bit          tmo[2]   = '{0, 0};
  bit          rsp_tmo[2] = '{0, 0};
  logic [15:0] m_adr[2] = '{16'h0, 16'h0};
  logic [7:0]  m_od[2]  = '{8'h0, 8'h0};
  logic [7:0]  m_rd[2]  = '{8'h0, 8'h0};

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
    end
  endtask

  // 0 idle, 1 setup, 2 strobe, 3 hold for the current cycle
  function automatic int phase(input int k);
    int r;
    if (!busy[k]) return 0;
    r = cyc - a[k];
    if (r <= TS) return 1;
    if (e[k] < 0 || cyc <= e[k]) return 2;
    return 3;
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (!n_reset) begin
        busy[k] = 0; m_adr[k] = '0; m_rd[k] = '0; m_od[k] = '0; rsp_c[k] = -1;
      end else if (busy[k]) begin
        if (phase(k) == 2 && cyc >= a[k] + TS + TSTR) begin
          int  w;
          bit  wl;
          w  = cyc - (a[k] + TS + TSTR);
          wl = !hist[(cyc - 2) & 7];
          if (!(wl && w < wmax[k])) begin
            e[k] = cyc; tmo[k] = wl;
            if (!m_wr[k]) m_rd[k] = i_data;
          end
        end
        if (e[k] >= 0 && cyc == e[k] + TH) begin
          busy[k] = 0; rsp_c[k] = cyc + 1; rsp_tmo[k] = tmo[k];
        end
      end else if (!rst_now && req_valid) begin
        busy[k] = 1; a[k] = cyc; e[k] = -1;
        m_wr[k] = req_write; m_io[k] = req_io; m_adr[k] = req_address; m_od[k] = req_wdata;
      end
    end
    hist[cyc & 7] = n_wait;
    rst_now = !n_reset;
    if (!n_reset) started = 1;
    cyc++;
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      if (rst_now) begin
        chk("ready", k, o_ready[k], 0);   chk("n_mereq", k, o_mereq[k], 1);
        chk("n_sltsl", k, o_sltsl[k], 1); chk("n_ioreq", k, o_ioreq[k], 1);
        chk("n_rd", k, o_rd[k], 1);       chk("n_wr", k, o_wr[k], 1);
        chk("is_output", k, o_isout[k], 0); chk("o_data", k, o_odata[k], 0);
        chk("adr", k, o_adr[k], 0);       chk("rsp_valid", k, o_rspv[k], 0);
        chk("rsp_rdata", k, o_rdata[k], 0); chk("rsp_timeout", k, o_tmo[k], 0);
      end else begin
        int ph;
        bit mem, strb, isout, rv;
        ph    = phase(k);
        mem   = (ph == 1 || ph == 2);
        strb  = (ph == 2);
        isout = (ph != 0) && m_wr[k];
        rv    = (cyc == rsp_c[k]);
        chk("ready", k, o_ready[k], !busy[k]);
        chk("n_mereq", k, o_mereq[k], !(mem && !m_io[k]));
        chk("n_sltsl", k, o_sltsl[k], !(mem && !m_io[k]));
        chk("n_ioreq", k, o_ioreq[k], !(mem && m_io[k]));
        chk("n_rd", k, o_rd[k], !(strb && !m_wr[k]));
        chk("n_wr", k, o_wr[k], !(strb && m_wr[k]));
        chk("is_output", k, o_isout[k], isout);
        if (isout) chk("o_data", k, o_odata[k], m_od[k]);
        chk("adr", k, o_adr[k], m_adr[k]);
        chk("rsp_valid", k, o_rspv[k], rv);
        chk("rsp_rdata", k, o_rdata[k], m_rd[k]);
        if (rv) chk("rsp_timeout", k, o_tmo[k], rsp_tmo[k]);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (started) compare();
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && (busy[0] || busy[1] || rst_now); i++) tick();
    if (busy[0] || busy[1] || rst_now) begin
      total++; bad++;
      $display("FAIL idle_wait cyc=%0d got=busy want=idle", cyc);
    end
  endtask

  task automatic start_txn(input bit w, input bit io, input logic [15:0] ad, input logic [7:0] wd);
    req_valid = 1'b1; req_write = w; req_io = io; req_address = ad; req_wdata = wd;
  endtask

  initial begin
    n_reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
    req_address = '0; req_wdata = '0; i_data = '0; n_wait = 1'b1;
    tick(); tick();
    chk("lit_rst_ready", 0, o_ready[0], 0);
    chk("lit_rst_adr", 0, o_adr[0], 0);
    n_reset = 1'b1;
    tick();
    chk("lit_ready_after_rst", 0, o_ready[0], 1);

    // memory read 0x4000
    wait_idle();
    i_data = 8'hA5;
    start_txn(0, 0, 16'h4000, 8'h00);
    for (int r = 1; r <= 9; r++) begin
      tick();
      if (r == 1) req_valid = 1'b0;
      chk("lit_rd_mereq", 0, o_mereq[0], (r <= 6) ? 1'b0 : 1'b1);
      chk("lit_rd_sltsl", 0, o_sltsl[0], (r <= 6) ? 1'b0 : 1'b1);
      chk("lit_rd_ioreq", 0, o_ioreq[0], 1);
      chk("lit_rd_nrd", 0, o_rd[0], (r >= 3 && r <= 6) ? 1'b0 : 1'b1);
      chk("lit_rd_rspv", 0, o_rspv[0], (r == 9) ? 1'b1 : 1'b0);
      if (r == 9) chk("lit_rd_rdata", 0, o_rdata[0], 16'h00A5);
    end

    // I/O write 0x98
    wait_idle();
    start_txn(1, 1, 16'h0098, 8'h3C);
    for (int r = 1; r <= 9; r++) begin
      tick();
      if (r == 1) req_valid = 1'b0;
      chk("lit_wr_ioreq", 0, o_ioreq[0], (r <= 6) ? 1'b0 : 1'b1);
      chk("lit_wr_nwr", 0, o_wr[0], (r >= 3 && r <= 6) ? 1'b0 : 1'b1);
      chk("lit_wr_isout", 0, o_isout[0], (r <= 8) ? 1'b1 : 1'b0);
      if (r <= 8) chk("lit_wr_odata", 0, o_odata[0], 16'h003C);
      chk("lit_wr_mereq", 0, o_mereq[0], 1);
      chk("lit_wr_sltsl", 0, o_sltsl[0], 1);
    end

    // n_wait low for 10 cycles during a read
    wait_idle();
    i_data = 8'h5A;
    start_txn(0, 0, 16'h1234, 8'h00);
    for (int r = 1; r <= 18; r++) begin
      tick();
      if (r == 1) req_valid = 1'b0;
      n_wait = (r >= 2 && r <= 11) ? 1'b0 : 1'b1;
      chk("lit_wait_nrd", 0, o_rd[0], (r >= 3 && r <= 14) ? 1'b0 : 1'b1);
      chk("lit_wait_rspv", 0, o_rspv[0], (r == 17) ? 1'b1 : 1'b0);
      if (r == 17) chk("lit_wait_tmo", 0, o_tmo[0], 0);
      chk("lit_to_nrd", 1, o_rd[1], (r >= 3 && r <= 10) ? 1'b0 : 1'b1);
      chk("lit_to_rspv", 1, o_rspv[1], (r == 13) ? 1'b1 : 1'b0);
      if (r == 13) chk("lit_to_tmo", 1, o_tmo[1], 1);
    end

    // back-to-back with req_valid held; fields wobble while busy
    wait_idle();
    start_txn(0, 0, 16'hA000, 8'h00);
    for (int r = 1; r <= 10; r++) begin
      tick();
      if (r < 9) begin
        req_address = 16'($urandom); req_write = 1'($urandom);
        req_io = 1'($urandom); req_wdata = 8'($urandom);
      end else if (r == 9) begin
        start_txn(1, 0, 16'h0BEE, 8'h77);
      end else begin
        req_valid = 1'b0;
      end
      chk("lit_b2b_ready", 0, o_ready[0], (r == 9) ? 1'b1 : 1'b0);
      chk("lit_b2b_rspv", 0, o_rspv[0], (r == 9) ? 1'b1 : 1'b0);
      chk("lit_b2b_adr", 0, o_adr[0], (r <= 9) ? 16'hA000 : 16'h0BEE);
      if (r == 10) chk("lit_b2b_isout", 0, o_isout[0], 1);
    end

    // reset pulse during a write strobe
    wait_idle();
    start_txn(1, 0, 16'h2222, 8'h11);
    for (int r = 1; r <= 12; r++) begin
      tick();
      if (r == 1) req_valid = 1'b0;
      if (r == 4) n_reset = 1'b0;
      if (r == 5) begin
        n_reset = 1'b1;
        chk("lit_abort_nwr", 0, o_wr[0], 1);
        chk("lit_abort_mereq", 0, o_mereq[0], 1);
        chk("lit_abort_isout", 0, o_isout[0], 0);
        chk("lit_abort_adr", 0, o_adr[0], 0);
      end
      if (r >= 5) chk("lit_abort_rspv", 0, o_rspv[0], 0);
      if (r == 6) chk("lit_abort_ready", 0, o_ready[0], 1);
    end

    // randomized traffic with wait bursts and rare resets
    begin
      int wrun = 0;
      for (int i = 0; i < 400; i++) begin
        tick();
        req_valid   = 1'($urandom);
        req_write   = 1'($urandom);
        req_io      = 1'($urandom);
        req_address = 16'($urandom);
        req_wdata   = 8'($urandom);
        i_data      = 8'($urandom);
        if (wrun > 0) begin
          n_wait = 1'b0; wrun--;
        end else if ($urandom_range(0, 15) == 0) begin
          n_wait = 1'b0; wrun = $urandom_range(1, 12);
        end else begin
          n_wait = 1'b1;
        end
        n_reset = ($urandom_range(0, 149) != 0);
      end
    end
    n_reset = 1'b1; req_valid = 1'b0; n_wait = 1'b1;
    wait_idle();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
